// File: rtl/cv32e41p_trace_pkg.sv
// cv32e41p_trace_pkg: configuration limits and shared types for the trace capture block.
package cv32e41p_trace_pkg;

    localparam int unsigned TRACE_MAX_CH    = 4;
    localparam int unsigned TRACE_MIN_DEPTH = 4;
    localparam int unsigned TRACE_MAX_DEPTH = 256;
    localparam int unsigned TRACE_TS_W      = 32;

    typedef logic [TRACE_TS_W-1:0] trace_ts_t;

    // Index width that never collapses to zero bits for a single channel.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cv32e41p_trace_rr_arbiter.sv
// cv32e41p_trace_rr_arbiter: grants one occupied staging slot per cycle in round-robin order.
module cv32e41p_trace_rr_arbiter
    import cv32e41p_trace_pkg::*;
#(
    parameter  int unsigned NUM_CH = 2,
    localparam int unsigned IW     = idx_w(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] req_i,
    output logic              gnt_vld_o,
    output logic [IW-1:0]     gnt_idx_o
);

    logic [IW-1:0] ptr_q;

    always_comb begin
        gnt_idx_o = '0;
        // Scan downward so the request closest to the pointer is written last and wins.
        for (int k = int'(NUM_CH) - 1; k >= 0; k--)
            if (req_i[(int'(ptr_q) + k) % int'(NUM_CH)])
                gnt_idx_o = IW'((int'(ptr_q) + k) % int'(NUM_CH));
    end

    assign gnt_vld_o = en_i & (|req_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            ptr_q <= '0;
        else if (clear_i)
            ptr_q <= '0;
        else if (gnt_vld_o)
            ptr_q <= (gnt_idx_o == IW'(NUM_CH - 1)) ? '0 : gnt_idx_o + IW'(1);
    end

endmodule

// File: rtl/cv32e41p_trace_capture.sv
// cv32e41p_trace_capture: per-channel staging merged round-robin into a shared trace FIFO.
// Defining CV32E41P_TRACE_TIMESTAMP_EN stamps each entry with a 32-bit cycle count on out_ts_o.
module cv32e41p_trace_capture
    import cv32e41p_trace_pkg::*;
#(
    parameter  int unsigned NUM_CH = 2,
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned DATA_W = 64,
    localparam int unsigned CH_W   = idx_w(NUM_CH),
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic                          wrap_mode_i,
    input  logic                          clear_i,
    input  logic [NUM_CH-1:0]             ch_valid_i,
    input  logic [NUM_CH-1:0][DATA_W-1:0] ch_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_W-1:0]             out_data_o,
    output logic [CH_W-1:0]               out_ch_o,
`ifdef CV32E41P_TRACE_TIMESTAMP_EN
    output trace_ts_t                     out_ts_o,
`endif
    output logic [AW:0]                   fill_o,
    output logic [NUM_CH-1:0][15:0]       drop_cnt_o,
    output logic                          overflow_o
);

    typedef struct packed {
        logic [DATA_W-1:0] payload;
        logic [CH_W-1:0]   ch;
`ifdef CV32E41P_TRACE_TIMESTAMP_EN
        trace_ts_t         ts;
`endif
    } entry_t;

    logic [NUM_CH-1:0]             stg_vld_q;
    logic [NUM_CH-1:0][DATA_W-1:0] stg_data_q;
    logic [NUM_CH-1:0]             gnt, load, drop;
    logic                          gnt_vld, full, pop, ovw;
    logic [CH_W-1:0]               gnt_idx;
    logic [AW-1:0]                 rd_q, wr_q;
    entry_t                        mem [DEPTH];
    entry_t                        head, wr_e;

    assign full        = fill_o == (AW+1)'(DEPTH);
    assign out_valid_o = |fill_o;
    assign pop         = out_valid_o & out_ready_i;
    // A grant into a full FIFO without a pop can only happen in wrap mode.
    assign ovw         = gnt_vld & full & ~pop;
    assign head        = mem[rd_q];
    assign out_data_o  = out_valid_o ? head.payload : '0;
    assign out_ch_o    = out_valid_o ? head.ch : '0;

    cv32e41p_trace_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .en_i      (~full | wrap_mode_i | pop),
        .req_i     (stg_vld_q),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            gnt[i]  = gnt_vld && (gnt_idx == CH_W'(i));
            load[i] = enable_i & ch_valid_i[i] & (~stg_vld_q[i] | gnt[i]);
            drop[i] = enable_i & ch_valid_i[i] & stg_vld_q[i] & ~gnt[i];
        end
    end

`ifdef CV32E41P_TRACE_TIMESTAMP_EN
    trace_ts_t                 ts_q;
    trace_ts_t [NUM_CH-1:0]    stg_ts_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            ts_q <= '0;
        else
            ts_q <= ts_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NUM_CH); i++)
            if (load[i])
                stg_ts_q[i] <= ts_q;
    end

    assign out_ts_o = out_valid_o ? head.ts : '0;
`endif

    always_comb begin
        wr_e.payload = stg_data_q[gnt_idx];
        wr_e.ch      = gnt_idx;
`ifdef CV32E41P_TRACE_TIMESTAMP_EN
        wr_e.ts      = stg_ts_q[gnt_idx];
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg_vld_q  <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            fill_o     <= '0;
        end else if (clear_i) begin
            stg_vld_q  <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            fill_o     <= '0;
        end else begin
            stg_vld_q  <= load | (stg_vld_q & ~gnt);
            overflow_o <= overflow_o | ovw | (|drop);
            for (int i = 0; i < int'(NUM_CH); i++)
                if (drop[i] && drop_cnt_o[i] != 16'hFFFF)
                    drop_cnt_o[i] <= drop_cnt_o[i] + 16'd1;
            wr_q   <= wr_q + AW'(gnt_vld);
            rd_q   <= rd_q + AW'(pop | ovw);
            fill_o <= fill_o + (AW+1)'(gnt_vld) - (AW+1)'(pop | ovw);
        end
    end

    // Payload storage needs no reset: validity lives in stg_vld_q and fill_o.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NUM_CH); i++)
            if (load[i])
                stg_data_q[i] <= ch_data_i[i];
        if (gnt_vld)
            mem[wr_q] <= wr_e;
    end

endmodule

// File: tb/tb_cv32e41p_trace_capture.sv
// tb_cv32e41p_trace_capture: scoreboard bench for the trace capture block (NUM_CH=2, DEPTH=4).
module tb_cv32e41p_trace_capture;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             wrap_mode = 1'b0;
    logic             clear = 1'b0;
    logic [1:0]       ch_valid = '0;
    logic [1:0][63:0] ch_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0]      out_data;
    logic [0:0]       out_ch;
    logic [2:0]       fill;
    logic [1:0][15:0] drop_cnt;
    logic             overflow;
`ifdef CV32E41P_TRACE_TIMESTAMP_EN
    logic [31:0]      out_ts;
`endif

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  ch;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cv32e41p_trace_capture #(.NUM_CH(2), .DEPTH(4), .DATA_W(64)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .wrap_mode_i (wrap_mode),
        .clear_i     (clear),
        .ch_valid_i  (ch_valid),
        .ch_data_i   (ch_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_ch_o    (out_ch),
`ifdef CV32E41P_TRACE_TIMESTAMP_EN
        .out_ts_o    (out_ts),
`endif
        .fill_o      (fill),
        .drop_cnt_o  (drop_cnt),
        .overflow_o  (overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_entry(input logic [63:0] d, input logic [1:0] ch);
        exp_t e;
        e.d  = d;
        e.ch = ch;
        sb.push_back(e);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic strobe_ch(input int ch, input logic [63:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            ch_valid       = 2'b00;
            ch_valid[ch]   = 1'b1;
            ch_data[ch]    = base + 64'(k);
            tick();
        end
        ch_valid = 2'b00;
    endtask

    // Every accepted head is compared against the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
            end else begin
                e.d  = 64'hDEAD_BEEF_DEAD_BEEF;
                e.ch = 2'd3;
            end
            check("pop_data", out_data, e.d);
            check("pop_ch", 64'(out_ch), 64'(e.ch));
        end
    end

    initial begin
        tick(3);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick(2);

        // Two-cycle latency from strobe to head
        out_ready = 1'b1;
        expect_entry(64'hA5, 2'd0);
        ch_valid   = 2'b01;
        ch_data[0] = 64'hA5;
        tick();
        ch_valid = 2'b00;
        check("lat_c1_valid", 64'(out_valid), 64'd0);
        tick();
        check("lat_c2_valid", 64'(out_valid), 64'd1);
        check("lat_c2_data", out_data, 64'hA5);
        check("lat_c2_ch", 64'(out_ch), 64'd0);
        tick(3);
        do_clear();

        // Both channels strobed for four cycles: alternating grants, three drops
        expect_entry(64'h100, 2'd0);
        expect_entry(64'h200, 2'd1);
        expect_entry(64'h101, 2'd0);
        expect_entry(64'h202, 2'd1);
        expect_entry(64'h103, 2'd0);
        for (int c = 0; c < 4; c++) begin
            ch_valid   = 2'b11;
            ch_data[0] = 64'h100 + 64'(c);
            ch_data[1] = 64'h200 + 64'(c);
            tick();
        end
        ch_valid = 2'b00;
        tick(8);
        check("rr_drop0", 64'(drop_cnt[0]), 64'd1);
        check("rr_drop1", 64'(drop_cnt[1]), 64'd2);
        check("rr_ovf", 64'(overflow), 64'd1);
        check("rr_fill", 64'(fill), 64'd0);
        do_clear();

        // Wrap mode: six pushes into four entries overwrite the two oldest
        out_ready = 1'b0;
        wrap_mode = 1'b1;
        strobe_ch(0, 64'h300, 6);
        tick(2);
        check("wrap_fill", 64'(fill), 64'd4);
        check("wrap_head", out_data, 64'h302);
        check("wrap_ovf", 64'(overflow), 64'd1);
        check("wrap_drop0", 64'(drop_cnt[0]), 64'd0);
        for (int k = 2; k < 6; k++)
            expect_entry(64'h300 + 64'(k), 2'd0);
        out_ready = 1'b1;
        tick(6);
        out_ready = 1'b0;
        check("wrap_drained", 64'(fill), 64'd0);
        do_clear();

        // Hold mode: FIFO fills, one strobe dropped, oldest stays at head
        wrap_mode = 1'b0;
        strobe_ch(0, 64'h400, 6);
        tick(2);
        check("hold_fill", 64'(fill), 64'd4);
        check("hold_head", out_data, 64'h400);
        check("hold_drop0", 64'(drop_cnt[0]), 64'd1);
        for (int k = 0; k < 5; k++)
            expect_entry(64'h400 + 64'(k), 2'd0);
        out_ready = 1'b1;
        tick(7);
        out_ready = 1'b0;
        check("hold_drained", 64'(fill), 64'd0);
        do_clear();

        // Full FIFO with simultaneous pop and grant
        strobe_ch(0, 64'h500, 5);
        tick(2);
        check("pp_fill_pre", 64'(fill), 64'd4);
        for (int k = 0; k < 5; k++)
            expect_entry(64'h500 + 64'(k), 2'd0);
        out_ready = 1'b1;
        tick();
        check("pp_fill", 64'(fill), 64'd4);
        check("pp_ovf", 64'(overflow), 64'd0);
        check("pp_head", out_data, 64'h501);
        tick(6);
        out_ready = 1'b0;
        check("pp_drained", 64'(fill), 64'd0);
        do_clear();

        // Clear with fill=3 and five drops on ch1, plus strobes in the clear cycle
        strobe_ch(1, 64'h600, 10);
        expect_entry(64'h600, 2'd1);
        expect_entry(64'h601, 2'd1);
        out_ready = 1'b1;
        tick(2);
        out_ready = 1'b0;
        check("clr_pre_fill", 64'(fill), 64'd3);
        check("clr_pre_drop1", 64'(drop_cnt[1]), 64'd5);
        check("clr_pre_ovf", 64'(overflow), 64'd1);
        clear      = 1'b1;
        ch_valid   = 2'b11;
        ch_data[0] = 64'h700;
        ch_data[1] = 64'h701;
        tick();
        clear    = 1'b0;
        ch_valid = 2'b00;
        check("clr_fill", 64'(fill), 64'd0);
        check("clr_valid", 64'(out_valid), 64'd0);
        check("clr_drop", 64'(drop_cnt), 64'd0);
        check("clr_ovf", 64'(overflow), 64'd0);
        tick(3);
        check("clr_no_stage", 64'(fill), 64'd0);

        // Strobes ignored while disabled; an already staged entry still drains
        enable = 1'b0;
        ch_valid   = 2'b01;
        ch_data[0] = 64'h777;
        tick(3);
        ch_valid = 2'b00;
        tick(3);
        check("dis_fill", 64'(fill), 64'd0);
        check("dis_drop", 64'(drop_cnt), 64'd0);
        enable = 1'b1;
        expect_entry(64'h800, 2'd0);
        ch_valid   = 2'b01;
        ch_data[0] = 64'h800;
        tick();
        ch_valid  = 2'b00;
        enable    = 1'b0;
        out_ready = 1'b1;
        tick(4);
        out_ready = 1'b0;
        enable    = 1'b1;
        check("dis_drained", 64'(fill), 64'd0);

        // Reset asserted mid-operation discards everything
        strobe_ch(0, 64'h900, 3);
        check("mrst_pre_fill", 64'(fill), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_fill", 64'(fill), 64'd0);
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_data", out_data, 64'd0);
        tick();
        rst_n = 1'b1;
        tick(3);
        check("mrst_post_fill", 64'(fill), 64'd0);
        check("mrst_post_valid", 64'(out_valid), 64'd0);

        check("sb_left", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
